// File: rtl/axi_arbiter.sv
// Two-to-one AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one slave.
// One whole transaction at a time, round-robin on ties, combinational routing from the owner state.
module axi_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_RD_IFU = 4'b0010,
        ST_RD_LSU = 4'b0100,
        ST_WR_LSU = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_last;        // 0 = IFU granted most recently, 1 = LSU
    logic   w_last_next;
    logic   w_ifu_req;
    logic   w_lsu_req;

    assign w_ifu_req = ifu_arvalid;
    assign w_lsu_req = lsu_arvalid | lsu_awvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;

        ifu_arready = 1'b0;
        ifu_rdata   = 32'h0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'h0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;

        s_araddr  = 32'h0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = 32'h0;
        s_awvalid = 1'b0;
        s_wdata   = 32'h0;
        s_wstrb   = 4'h0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On a tie the master not named by r_last wins; an LSU read beats its own write.
                if (w_ifu_req && (!w_lsu_req || r_last)) begin
                    w_state_next = ST_RD_IFU;
                    w_last_next  = 1'b0;
                end else if (w_lsu_req) begin
                    w_state_next = lsu_arvalid ? ST_RD_LSU : ST_WR_LSU;
                    w_last_next  = 1'b1;
                end
            end

            ST_RD_IFU: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid;
                s_rready    = ifu_rready;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                if (s_rvalid && ifu_rready) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_RD_LSU: begin
                s_araddr    = lsu_araddr;
                s_arvalid   = lsu_arvalid;
                s_rready    = lsu_rready;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                if (s_rvalid && lsu_rready) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_WR_LSU: begin
                s_awaddr    = lsu_awaddr;
                s_awvalid   = lsu_awvalid;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wvalid    = lsu_wvalid;
                s_bready    = lsu_bready;
                lsu_awready = s_awready;
                lsu_wready  = s_wready;
                lsu_bvalid  = s_bvalid;
                lsu_bresp   = s_bresp;
                if (s_bvalid && lsu_bready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with a small SRAM-like AXI-Lite slave model.
// Addresses with top bits 0xBAD answer SLVERR so response pass-through can be observed.
module tb_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] ifu_araddr = 32'h0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b1;

    logic [31:0] lsu_araddr = 32'h0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b1;
    logic [31:0] lsu_awaddr = 32'h0;
    logic        lsu_awvalid = 1'b0;
    logic        lsu_awready;
    logic [31:0] lsu_wdata = 32'h0;
    logic [3:0]  lsu_wstrb = 4'h0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready = 1'b1;

    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    int n_vec = 0;
    int n_err = 0;
    int grant_log[$];
    int b_count = 0;

    axi_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clock = ~clock;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    logic        sl_rvalid, sl_bvalid;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rresp, sl_bresp;

    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[13:12], a[9:2]};
    endfunction

    assign s_arready = ~sl_rvalid;
    assign s_rvalid  = sl_rvalid;
    assign s_rdata   = sl_rdata;
    assign s_rresp   = sl_rresp;
    assign s_awready = s_awvalid & s_wvalid & ~sl_bvalid;
    assign s_wready  = s_awvalid & s_wvalid & ~sl_bvalid;
    assign s_bvalid  = sl_bvalid;
    assign s_bresp   = sl_bresp;

    always @(posedge clock) begin
        if (reset) begin
            sl_rvalid <= 1'b0;
            sl_rdata  <= 32'h0;
            sl_rresp  <= 2'b00;
            sl_bvalid <= 1'b0;
            sl_bresp  <= 2'b00;
        end else begin
            if (s_arvalid && s_arready) begin
                sl_rvalid <= 1'b1;
                if (s_araddr[31:20] == 12'hBAD) begin
                    sl_rdata <= 32'h0;
                    sl_rresp <= 2'b10;
                end else begin
                    sl_rdata <= mem[midx(s_araddr)];
                    sl_rresp <= 2'b00;
                end
            end else if (sl_rvalid && s_rready) begin
                sl_rvalid <= 1'b0;
            end
            if (s_awvalid && s_awready && s_wvalid && s_wready) begin
                sl_bvalid <= 1'b1;
                if (s_awaddr[31:20] == 12'hBAD) begin
                    sl_bresp <= 2'b10;
                end else begin
                    sl_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[midx(s_awaddr)][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end else if (sl_bvalid && s_bready) begin
                sl_bvalid <= 1'b0;
            end
        end
    end

    // Grant order as seen at the slave: 0 = IFU read, 1 = LSU read, 2 = LSU write.
    always @(posedge clock) begin
        if (!reset) begin
            if (s_arvalid && s_arready) grant_log.push_back(ifu_arready ? 0 : 1);
            if (s_awvalid && s_awready) grant_log.push_back(2);
            if (lsu_bvalid && lsu_bready) b_count++;
        end
    end

    logic [104:0] all_s_out;
    logic [76:0]  all_m_out;
    assign all_s_out = {s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
    assign all_m_out = {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rresp,
                        lsu_rvalid, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid};

    // ---------------- master helpers ----------------
    task automatic do_read(input bit use_lsu, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        bit got = 0;
        data = 32'h0;
        resp = 2'b00;
        if (use_lsu) begin lsu_araddr = addr; lsu_arvalid = 1'b1; end
        else begin ifu_araddr = addr; ifu_arvalid = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (use_lsu && lsu_rvalid) begin
                data = lsu_rdata; resp = lsu_rresp; got = 1; lsu_arvalid = 1'b0; break;
            end
            if (!use_lsu && ifu_rvalid) begin
                data = ifu_rdata; resp = ifu_rresp; got = 1; ifu_arvalid = 1'b0; break;
            end
        end
        lsu_arvalid = 1'b0;
        ifu_arvalid = 1'b0;
        n_vec++;
        if (got !== 1'b1) begin
            n_err++;
            $display("FAIL read_timeout: master=%0d addr=%h rvalid seen=%0d required=1", use_lsu, addr, got);
        end
        $display("read  master=%s addr=%h data=%h resp=%0d", use_lsu ? "LSU" : "IFU", addr, data, resp);
        @(negedge clock);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        bit got = 0;
        resp = 2'b00;
        lsu_awaddr = addr; lsu_awvalid = 1'b1;
        lsu_wdata = data; lsu_wstrb = strb; lsu_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (lsu_bvalid) begin resp = lsu_bresp; got = 1; break; end
        end
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        n_vec++;
        if (got !== 1'b1) begin
            n_err++;
            $display("FAIL write_timeout: addr=%h bvalid seen=%0d required=1", addr, got);
        end
        $display("write master=LSU addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, resp);
        @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if (all_s_out !== '0) begin
            n_err++; $display("FAIL reset_slave_side: got=%h required=0", all_s_out);
        end
        n_vec++;
        if (all_m_out !== '0) begin
            n_err++; $display("FAIL reset_master_side: got=%h required=0", all_m_out);
        end
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({all_s_out, all_m_out} !== '0) begin
            n_err++; $display("FAIL reset_first_cycle: got=%h required=0", {all_s_out, all_m_out});
        end
        $display("reset released, outputs idle");
    endtask

    task automatic test_ifu_read();
        logic [31:0] data = 32'h0;
        logic [1:0]  resp = 2'b00;
        int lat = -1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        @(negedge clock);
        n_vec++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) begin
            n_err++; $display("FAIL ifu_grant_latency: s_arvalid=%b s_araddr=%h required 1/80000000", s_arvalid, s_araddr);
        end
        for (int i = 0; i < 20; i++) begin
            if (ifu_rvalid) begin data = ifu_rdata; resp = ifu_rresp; lat = i; break; end
            @(negedge clock);
        end
        ifu_arvalid = 1'b0;
        n_vec++;
        if (lat !== 1) begin
            n_err++; $display("FAIL ifu_rvalid_latency: got=%0d required=1", lat);
        end
        n_vec++;
        if (data !== 32'h1234_5678 || resp !== 2'b00) begin
            n_err++; $display("FAIL ifu_rdata: got=%h/%0d required=12345678/0", data, resp);
        end
        @(negedge clock);
        n_vec++;
        if ({s_arvalid, s_rready, ifu_rvalid, ifu_arready} !== 4'b0) begin
            n_err++; $display("FAIL ifu_back_to_idle: got=%b required=0000", {s_arvalid, s_rready, ifu_rvalid, ifu_arready});
        end
        $display("read  master=IFU addr=80000000 data=%h latency=%0d", data, lat);
    endtask

    task automatic test_lsu_write();
        logic [1:0]  bresp;
        logic [31:0] data;
        logic [1:0]  resp;
        int b0 = b_count;
        do_write(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, bresp);
        repeat (3) @(negedge clock);
        n_vec++;
        if (b_count - b0 !== 1 || bresp !== 2'b00) begin
            n_err++; $display("FAIL lsu_write_b: pulses=%0d bresp=%0d required 1/0", b_count - b0, bresp);
        end
        do_read(1'b1, 32'h8000_1000, data, resp);
        n_vec++;
        if (data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL lsu_readback: got=%h required=deadbeef", data);
        end
    endtask

    task automatic test_contention();
        int exp_order[4] = '{0, 1, 0, 1};
        int done = 0, viol = 0, bad_data = 0;
        bit prev_r = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        grant_log.delete();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
        for (int i = 0; i < 100 && done < 4; i++) begin
            @(negedge clock);
            if (prev_r && (s_arvalid || s_awvalid)) viol++;
            prev_r = ifu_rvalid | lsu_rvalid;
            if (ifu_rvalid) begin
                done++;
                if (ifu_rdata !== 32'h1234_5678) bad_data++;
                $display("read  master=IFU addr=80000000 data=%h (contention #%0d)", ifu_rdata, done);
            end
            if (lsu_rvalid) begin
                done++;
                if (lsu_rdata !== 32'hDEAD_BEEF) bad_data++;
                $display("read  master=LSU addr=80001000 data=%h (contention #%0d)", lsu_rdata, done);
            end
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (grant_log.size() !== 4) begin
            n_err++; $display("FAIL contention_count: got=%0d required=4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (grant_log[k] !== exp_order[k]) begin
                    n_err++; $display("FAIL contention_order[%0d]: got=%0d required=%0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
        n_vec++;
        if (viol !== 0) begin
            n_err++; $display("FAIL idle_gap: back-to-back grants=%0d required=0", viol);
        end
        n_vec++;
        if (bad_data !== 0) begin
            n_err++; $display("FAIL contention_data: bad words=%0d required=0", bad_data);
        end
    endtask

    task automatic test_lsu_rw_together();
        bit rd_done = 0, got_b = 0, aw_early = 0;
        logic [31:0] rdata = 32'h0;
        logic [1:0]  bresp = 2'b11;
        logic [31:0] data;
        logic [1:0]  resp;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
        lsu_awaddr = 32'h8000_2000; lsu_awvalid = 1'b1;
        lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (s_awvalid && !rd_done) aw_early = 1;
            if (lsu_rvalid) begin rd_done = 1; rdata = lsu_rdata; lsu_arvalid = 1'b0; end
            if (lsu_bvalid) begin got_b = 1; bresp = lsu_bresp; break; end
        end
        lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(negedge clock);
        $display("read  master=LSU addr=80001000 data=%h (paired with write)", rdata);
        $display("write master=LSU addr=80002000 data=cafef00d bresp=%0d", bresp);
        n_vec++;
        if (rd_done !== 1'b1 || aw_early !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rw_read_first: done=%0d aw_early=%0d rdata=%h required 1/0/deadbeef", rd_done, aw_early, rdata);
        end
        n_vec++;
        if (got_b !== 1'b1 || bresp !== 2'b00) begin
            n_err++; $display("FAIL rw_write_done: got_b=%0d bresp=%0d required 1/0", got_b, bresp);
        end
        do_read(1'b1, 32'h8000_2000, data, resp);
        n_vec++;
        if (data !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL rw_readback: got=%h required=cafef00d", data);
        end
    endtask

    task automatic test_isolation();
        int iso_err = 0, extra = 0;
        bit got = 0;
        logic [31:0] data = 32'h0;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
        lsu_awaddr = 32'h8000_3000; lsu_awvalid = 1'b1;
        lsu_wdata = 32'h0000_0011; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ({lsu_arready, lsu_rvalid, lsu_awready, lsu_wready} !== 4'b0 || lsu_rdata !== 32'h0) iso_err++;
            if (ifu_rvalid) begin got = 1; data = ifu_rdata; break; end
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (s_arvalid || s_awvalid) extra++;
        end
        $display("read  master=IFU addr=80000000 data=%h (LSU held off)", data);
        n_vec++;
        if (got !== 1'b1 || data !== 32'h1234_5678) begin
            n_err++; $display("FAIL iso_ifu_read: got=%0d data=%h required 1/12345678", got, data);
        end
        n_vec++;
        if (iso_err !== 0) begin
            n_err++; $display("FAIL iso_lsu_quiet: leaking cycles=%0d required=0", iso_err);
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++; $display("FAIL iso_withdraw: grants after withdrawal=%0d required=0", extra);
        end
    endtask

    task automatic test_error_resp();
        logic [31:0] data;
        logic [1:0]  resp;
        logic [1:0]  bresp;
        do_read(1'b1, 32'hBAD0_0000, data, resp);
        n_vec++;
        if (resp !== 2'b10) begin
            n_err++; $display("FAIL err_rresp: got=%0d required=2", resp);
        end
        do_write(32'hBAD0_0004, 32'h5555_AAAA, 4'hF, bresp);
        n_vec++;
        if (bresp !== 2'b10) begin
            n_err++; $display("FAIL err_bresp: got=%0d required=2", bresp);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] data;
        logic [1:0]  resp;
        lsu_awaddr = 32'h8000_3000; lsu_awvalid = 1'b1;
        lsu_wdata = 32'h0BAD_F00D; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
        @(negedge clock);
        n_vec++;
        if (s_awvalid !== 1'b1 || lsu_bvalid !== 1'b0) begin
            n_err++; $display("FAIL midrst_in_write: s_awvalid=%b bvalid=%b required 1/0", s_awvalid, lsu_bvalid);
        end
        reset = 1'b1;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({all_s_out, all_m_out} !== '0) begin
            n_err++; $display("FAIL midrst_outputs: got=%h required=0", {all_s_out, all_m_out});
        end
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({all_s_out, all_m_out} !== '0) begin
            n_err++; $display("FAIL midrst_idle: got=%h required=0", {all_s_out, all_m_out});
        end
        $display("reset pulse during write, transaction abandoned");
        do_read(1'b0, 32'h8000_0000, data, resp);
        n_vec++;
        if (data !== 32'h1234_5678 || resp !== 2'b00) begin
            n_err++; $display("FAIL midrst_fresh_read: got=%h/%0d required=12345678/0", data, resp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h1234_5678;
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_contention();
        test_lsu_rw_together();
        test_isolation();
        test_error_resp();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
